// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks destination registers of DEPTH in-flight pipeline
// stages (stage 0 youngest) and produces operand-forwarding selects plus a
// load-use stall for the instruction currently in decode.
//
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   ADVANCE            pipeline moves this cycle
//   FLUSH              squash the youngest FLUSH_DEPTH stages
//   IN_VALID           decoded instruction valid
//   RS1_SEL, RS2_SEL   decoded source registers
//   RD_IN, TYPE_IN     decoded destination and op type (00 idle, 01 alu, 10 load, 11 store)
//   MUX1_SEL, MUX2_SEL forwarding select (0 = regfile, k = stage k-1), combinational
//   RS1_TYPE, RS2_TYPE type of the selected stage (00 for regfile), combinational
//   STALL              load-use hazard, combinational
//   STALL_COUNT        stall cycles that coincided with ADVANCE; present only
//                      when macro HAZARD_SB_STALL_CNT_EN is defined
module hazard_scoreboard #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned LOAD_LAT    = 2,
  parameter int unsigned FLUSH_DEPTH = 2,
  localparam int unsigned SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ADVANCE,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  input  logic [REG_AW-1:0] RS1_SEL,
  input  logic [REG_AW-1:0] RS2_SEL,
  input  logic [REG_AW-1:0] RD_IN,
  input  logic [1:0]        TYPE_IN,
  output logic [SEL_W-1:0]  MUX1_SEL,
  output logic [SEL_W-1:0]  MUX2_SEL,
  output logic [1:0]        RS1_TYPE,
  output logic [1:0]        RS2_TYPE,
  output logic              STALL
`ifdef HAZARD_SB_STALL_CNT_EN
  ,
  output logic [31:0]       STALL_COUNT
`endif
);

  localparam logic [1:0] TYPE_ALU   = 2'b01;
  localparam logic [1:0] TYPE_LOAD  = 2'b10;

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][REG_AW-1:0] rd_q, rd_d;
  logic [DEPTH-1:0][1:0]        type_q, type_d;
  logic [DEPTH-1:0]             producer;
  logic                         early1, early2;

  // A stage can supply a value only if it writes a non-zero register.
  always_comb begin
    producer = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      producer[k] = valid_q[k] && (type_q[k] == TYPE_ALU || type_q[k] == TYPE_LOAD)
                    && (rd_q[k] != '0);
    end
  end

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    MUX1_SEL = '0;
    MUX2_SEL = '0;
    RS1_TYPE = 2'b00;
    RS2_TYPE = 2'b00;
    early1   = 1'b0;
    early2   = 1'b0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (producer[k] && (RS1_SEL != '0) && (rd_q[k] == RS1_SEL)) begin
        MUX1_SEL = SEL_W'(k + 1);
        RS1_TYPE = type_q[k];
        early1   = (type_q[k] == TYPE_LOAD) && (k < int'(LOAD_LAT));
      end
      if (producer[k] && (RS2_SEL != '0) && (rd_q[k] == RS2_SEL)) begin
        MUX2_SEL = SEL_W'(k + 1);
        RS2_TYPE = type_q[k];
        early2   = (type_q[k] == TYPE_LOAD) && (k < int'(LOAD_LAT));
      end
    end
    STALL = IN_VALID && (early1 || early2);
  end

  // Shift on ADVANCE, bubble stage 0 when stalled/idle, then apply FLUSH.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    type_d  = type_q;
    if (ADVANCE) begin
      for (int i = int'(DEPTH) - 1; i >= 1; i--) begin
        valid_d[i] = valid_q[i-1];
        rd_d[i]    = rd_q[i-1];
        type_d[i]  = type_q[i-1];
      end
      if (IN_VALID && !STALL) begin
        valid_d[0] = 1'b1;
        rd_d[0]    = RD_IN;
        type_d[0]  = TYPE_IN;
      end else begin
        valid_d[0] = 1'b0;
        rd_d[0]    = '0;
        type_d[0]  = 2'b00;
      end
    end
    if (FLUSH) begin
      for (int i = 0; i < int'(FLUSH_DEPTH); i++) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
      rd_q    <= '0;
      type_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      type_q  <= type_d;
    end
  end

`ifdef HAZARD_SB_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Free-running wrap on overflow.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (STALL && ADVANCE) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign STALL_COUNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (DEPTH=4, REG_AW=5, LOAD_LAT=2, FLUSH_DEPTH=2).
module tb_hazard_scoreboard;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ADVANCE;
  logic       FLUSH;
  logic       IN_VALID;
  logic [4:0] RS1_SEL, RS2_SEL, RD_IN;
  logic [1:0] TYPE_IN;
  logic [2:0] MUX1_SEL, MUX2_SEL;
  logic [1:0] RS1_TYPE, RS2_TYPE;
  logic       STALL;
`ifdef HAZARD_SB_STALL_CNT_EN
  logic [31:0] STALL_COUNT;
`endif

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  hazard_scoreboard dut (
    .CLK      (CLK),
    .RST      (RST),
    .ADVANCE  (ADVANCE),
    .FLUSH    (FLUSH),
    .IN_VALID (IN_VALID),
    .RS1_SEL  (RS1_SEL),
    .RS2_SEL  (RS2_SEL),
    .RD_IN    (RD_IN),
    .TYPE_IN  (TYPE_IN),
    .MUX1_SEL (MUX1_SEL),
    .MUX2_SEL (MUX2_SEL),
    .RS1_TYPE (RS1_TYPE),
    .RS2_TYPE (RS2_TYPE),
    .STALL    (STALL)
`ifdef HAZARD_SB_STALL_CNT_EN
    ,
    .STALL_COUNT (STALL_COUNT)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive decode inputs (advance/flush left as-is).
  task automatic dec(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic [1:0] ty);
    IN_VALID = v;
    RS1_SEL  = rs1;
    RS2_SEL  = rs2;
    RD_IN    = rd;
    TYPE_IN  = ty;
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [1:0] ty);
    ADVANCE = 1'b1;
    dec(1'b1, 5'd0, 5'd0, rd, ty);
    tick();
    ADVANCE = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    ADVANCE = 1'b0;
    FLUSH = 1'b0;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; ADVANCE = 1'b0; FLUSH = 1'b0;
    IN_VALID = 1'b0; RS1_SEL = '0; RS2_SEL = '0; RD_IN = '0; TYPE_IN = '0;
    tick();
    tick();
    RST = 1'b0;

    // Reset state with arbitrary decode inputs
    dec(1'b1, 5'd5, 5'd7, 5'd9, 2'b10);
    chk("rst_mux1", 32'(MUX1_SEL), 32'd0);
    chk("rst_mux2", 32'(MUX2_SEL), 32'd0);
    chk("rst_t1", 32'(RS1_TYPE), 32'd0);
    chk("rst_t2", 32'(RS2_TYPE), 32'd0);
    chk("rst_stall", 32'(STALL), 32'd0);

    // Forward ALU from stage 0
    issue(5'd5, 2'b01);
    dec(1'b1, 5'd5, 5'd0, 5'd0, 2'b00);
    chk("alu_mux1", 32'(MUX1_SEL), 32'd1);
    chk("alu_t1", 32'(RS1_TYPE), 32'd1);
    chk("alu_stall", 32'(STALL), 32'd0);

    // Load-use
    do_reset();
    issue(5'd7, 2'b10);
    dec(1'b0, 5'd0, 5'd7, 5'd9, 2'b01);
    chk("lu_novalid_stall", 32'(STALL), 32'd0);
    chk("lu_novalid_mux2", 32'(MUX2_SEL), 32'd1);
    ADVANCE = 1'b1;
    dec(1'b1, 5'd0, 5'd7, 5'd9, 2'b01);
    chk("lu_s0_stall", 32'(STALL), 32'd1);
    chk("lu_s0_mux2", 32'(MUX2_SEL), 32'd1);
    chk("lu_s0_t2", 32'(RS2_TYPE), 32'd2);
    tick();
    chk("lu_s1_stall", 32'(STALL), 32'd1);
    chk("lu_s1_mux2", 32'(MUX2_SEL), 32'd2);
    tick();
    chk("lu_s2_stall", 32'(STALL), 32'd0);
    chk("lu_s2_mux2", 32'(MUX2_SEL), 32'd3);
    chk("lu_s2_t2", 32'(RS2_TYPE), 32'd2);
    tick();
    ADVANCE = 1'b0;
    dec(1'b0, 5'd9, 5'd7, 5'd0, 2'b00);
    chk("lu_after_mux1", 32'(MUX1_SEL), 32'd1);
    chk("lu_after_t1", 32'(RS1_TYPE), 32'd1);
    chk("lu_after_mux2", 32'(MUX2_SEL), 32'd4);

    // Youngest match wins; x0 and stores never forward
    do_reset();
    issue(5'd3, 2'b01);
    issue(5'd4, 2'b01);
    issue(5'd3, 2'b01);
    dec(1'b1, 5'd3, 5'd4, 5'd0, 2'b00);
    chk("yw_mux1", 32'(MUX1_SEL), 32'd1);
    chk("yw_mux2", 32'(MUX2_SEL), 32'd2);
    do_reset();
    issue(5'd0, 2'b01);
    dec(1'b1, 5'd0, 5'd0, 5'd0, 2'b00);
    chk("x0_mux1", 32'(MUX1_SEL), 32'd0);
    chk("x0_t1", 32'(RS1_TYPE), 32'd0);
    issue(5'd6, 2'b11);
    dec(1'b1, 5'd0, 5'd6, 5'd0, 2'b00);
    chk("store_mux2", 32'(MUX2_SEL), 32'd0);
    chk("store_t2", 32'(RS2_TYPE), 32'd0);

    // Freeze with pending hazard, then resume
    do_reset();
    issue(5'd8, 2'b10);
    dec(1'b1, 5'd8, 5'd0, 5'd10, 2'b01);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("frz_stall", 32'(STALL), 32'd1);
      chk("frz_mux1", 32'(MUX1_SEL), 32'd1);
    end
    ADVANCE = 1'b1;
    tick();
    chk("res_s1_stall", 32'(STALL), 32'd1);
    chk("res_s1_mux1", 32'(MUX1_SEL), 32'd2);
    tick();
    chk("res_s2_stall", 32'(STALL), 32'd0);
    chk("res_s2_mux1", 32'(MUX1_SEL), 32'd3);
`ifdef HAZARD_SB_STALL_CNT_EN
    chk("stall_count", STALL_COUNT, 32'd2);
`endif
    ADVANCE = 1'b0;

    // Flush with advance
    do_reset();
    issue(5'd1, 2'b01);
    issue(5'd2, 2'b01);
    issue(5'd3, 2'b01);
    issue(5'd4, 2'b01);
    dec(1'b0, 5'd4, 5'd1, 5'd0, 2'b00);
    chk("fl_pre_mux1", 32'(MUX1_SEL), 32'd1);
    chk("fl_pre_mux2", 32'(MUX2_SEL), 32'd4);
    FLUSH = 1'b1;
    ADVANCE = 1'b1;
    dec(1'b1, 5'd0, 5'd0, 5'd5, 2'b01);
    tick();
    FLUSH = 1'b0;
    ADVANCE = 1'b0;
    dec(1'b0, 5'd3, 5'd2, 5'd0, 2'b00);
    chk("fl_x3_mux1", 32'(MUX1_SEL), 32'd3);
    chk("fl_x2_mux2", 32'(MUX2_SEL), 32'd4);
    dec(1'b0, 5'd5, 5'd4, 5'd0, 2'b00);
    chk("fl_x5_gone", 32'(MUX1_SEL), 32'd0);
    chk("fl_x4_gone", 32'(MUX2_SEL), 32'd0);

    // Flush without advance: youngest squashed, older stages stay put
    issue(5'd6, 2'b01);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    dec(1'b0, 5'd6, 5'd3, 5'd0, 2'b00);
    chk("fl_noadv_x6", 32'(MUX1_SEL), 32'd0);
    chk("fl_noadv_x3", 32'(MUX2_SEL), 32'd4);

    // Flush concurrent with reset clears everything
    RST = 1'b1;
    FLUSH = 1'b1;
    ADVANCE = 1'b1;
    tick();
    RST = 1'b0;
    FLUSH = 1'b0;
    ADVANCE = 1'b0;
    dec(1'b1, 5'd3, 5'd3, 5'd0, 2'b00);
    chk("flrst_mux1", 32'(MUX1_SEL), 32'd0);
    chk("flrst_mux2", 32'(MUX2_SEL), 32'd0);
    chk("flrst_stall", 32'(STALL), 32'd0);

    // Reset mid-stall discards the pending load
    issue(5'd12, 2'b10);
    dec(1'b1, 5'd12, 5'd0, 5'd0, 2'b01);
    chk("rms_stall_pre", 32'(STALL), 32'd1);
    do_reset();
    chk("rms_stall_post", 32'(STALL), 32'd0);
    chk("rms_mux1_post", 32'(MUX1_SEL), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
